// File: rtl/card_deck_store_if.sv
// card_deck_store_if
//   Command/response bundle between game control logic (master) and the
//   card deck store (slave).
//
//   cmd_valid / cmd / cmd_ready : command handshake (DRAW, RETURN, SWAP, INIT)
//   in_value / in_suit          : card operand for RETURN
//   idx_a / idx_b               : slot operands for SWAP (0 = bottom of deck)
//   out_valid / card            : drawn card, {2'b00, value, suit}
//   count / empty / full        : deck occupancy
//   error                       : accepted command was rejected
interface card_deck_store_if #(
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic [1:0]        cmd;
    logic              cmd_ready;
    logic [3:0]        in_value;
    logic [1:0]        in_suit;
    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] idx_b;
    logic              out_valid;
    logic [7:0]        card;
    logic [ADDR_W-1:0] count;
    logic              empty;
    logic              full;
    logic              error;

    modport master (
        output cmd_valid, cmd, in_value, in_suit, idx_a, idx_b,
        input  cmd_ready, out_valid, card, count, empty, full, error
    );

    modport slave (
        input  cmd_valid, cmd, in_value, in_suit, idx_a, idx_b,
        output cmd_ready, out_valid, card, count, empty, full, error
    );
endinterface

// File: rtl/card_deck_store.sv
// card_deck_store
//   Stack-organised deck of up to DEPTH cards, each stored as 6-bit
//   {value, suit}. The top of the deck is slot count-1.
//   Commands: DRAW pops the top card, RETURN pushes a card, SWAP exchanges
//   two slots over two extra cycles, INIT writes a standard ordered deck of
//   min(DEPTH, 52) cards, one slot per cycle.
//
//   clock : system clock, all state updates on the rising edge
//   reset : asynchronous, active-high
//   bus   : card_deck_store_if slave modport (handshake, operands, results)
module card_deck_store #(
    parameter int DEPTH  = 52,
    parameter int ADDR_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    card_deck_store_if.slave   bus
);
    localparam int N_INIT = (DEPTH < 52) ? DEPTH : 52;
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] DEPTH_C   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(N_INIT - 1);

    localparam logic [1:0] CMD_DRAW   = 2'b00;
    localparam logic [1:0] CMD_RETURN = 2'b01;
    localparam logic [1:0] CMD_SWAP   = 2'b10;
    localparam logic [1:0] CMD_INIT   = 2'b11;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SWAP_RD = 2'd1;
    localparam logic [1:0] SWAP_WR = 2'd2;
    localparam logic [1:0] INIT    = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] count_q;
    logic [7:0]        card_q;
    logic              out_valid_q;
    logic              error_q;
    logic [SLOT_W-1:0] swap_a;
    logic [SLOT_W-1:0] swap_b;
    logic [3:0]        init_value;
    logic [1:0]        init_suit;

    logic [5:0]        slot [DEPTH];
    logic [5:0]        tmp_a;
    logic [5:0]        tmp_b;

    logic              cmd_ready;
    logic              accept;
    logic              can_draw;
    logic              can_return;
    logic              can_swap;
    logic              return_fire;
    logic [SLOT_W-1:0] wr_slot;
    logic [SLOT_W-1:0] top_slot;

    // Ready is gated by the reset input itself so it is low for the whole
    // time reset is held, not just after the next edge.
    assign cmd_ready   = (state == IDLE) && !reset;
    assign accept      = bus.cmd_valid && cmd_ready;

    assign can_draw    = (count_q != '0);
    assign can_return  = (count_q < DEPTH_C) &&
                         (bus.in_value >= 4'd1) && (bus.in_value <= 4'd13);
    assign can_swap    = (bus.idx_a < count_q) && (bus.idx_b < count_q);
    assign return_fire = accept && (bus.cmd == CMD_RETURN) && can_return;

    // Slot addresses only need enough bits to span DEPTH; every write using
    // wr_slot is guarded so count_q < DEPTH, and top_slot is only used when
    // count_q > 0, so the truncation never aliases.
    assign wr_slot  = count_q[SLOT_W-1:0];
    assign top_slot = count_q[SLOT_W-1:0] - 1'b1;

    // Control state: FSM, occupancy, output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count_q     <= '0;
            card_q      <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            swap_a      <= '0;
            swap_b      <= '0;
            init_value  <= 4'd1;
            init_suit   <= 2'd0;
        end else begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.cmd)
                            CMD_DRAW: begin
                                if (can_draw) begin
                                    card_q      <= {2'b00, slot[top_slot]};
                                    count_q     <= count_q - 1'b1;
                                    out_valid_q <= 1'b1;
                                end else begin
                                    error_q <= 1'b1;
                                end
                            end
                            CMD_RETURN: begin
                                if (can_return) begin
                                    count_q <= count_q + 1'b1;
                                end else begin
                                    error_q <= 1'b1;
                                end
                            end
                            CMD_SWAP: begin
                                if (can_swap) begin
                                    swap_a <= bus.idx_a[SLOT_W-1:0];
                                    swap_b <= bus.idx_b[SLOT_W-1:0];
                                    state  <= SWAP_RD;
                                end else begin
                                    error_q <= 1'b1;
                                end
                            end
                            default: begin  // CMD_INIT
                                count_q    <= '0;
                                init_value <= 4'd1;
                                init_suit  <= 2'd0;
                                state      <= INIT;
                            end
                        endcase
                    end
                end
                SWAP_RD: state <= SWAP_WR;
                SWAP_WR: state <= IDLE;
                default: begin  // INIT: one ordered card per cycle
                    count_q <= count_q + 1'b1;
                    if (init_value == 4'd13) begin
                        init_value <= 4'd1;
                        init_suit  <= init_suit + 1'b1;
                    end else begin
                        init_value <= init_value + 1'b1;
                    end
                    if (count_q == LAST_INIT) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Card storage and swap temporaries.
    // NOTE: the slot array is deliberately left out of reset; only count
    // defines which slots are meaningful, and a reset on a memory would
    // block RAM/array inference and cost a reset net to every bit.
    always_ff @(posedge clock) begin
        if (return_fire) begin
            slot[wr_slot] <= {bus.in_value, bus.in_suit};
        end
        if (state == INIT) begin
            slot[wr_slot] <= {init_value, init_suit};
        end
        if (state == SWAP_RD) begin
            tmp_a <= slot[swap_a];
            tmp_b <= slot[swap_b];
        end
        // With swap_a == swap_b both writes carry the same data.
        if (state == SWAP_WR) begin
            slot[swap_a] <= tmp_b;
            slot[swap_b] <= tmp_a;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.card      = card_q;
    assign bus.count     = count_q;
    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == DEPTH_C);
    assign bus.error     = error_q;
endmodule

// File: doc/card_deck_store.md
# card_deck_store

Parametrised card deck store holding up to DEPTH cards in the same 6-bit {value, suit} encoding used by store_card (value 1..13, suit 0..3). It sits between game control logic and the display/hand logic. It replaces single-address card storage with a stack-organised deck supporting four commands: draw, return, swap and initialise. Swap gives the shuffle engine its primitive; init fills a standard ordered deck.

## Interface
- DEPTH, 52, number of card slots (1..63)
- ADDR_W, 6, width of count and index fields; must satisfy 2^ADDR_W > DEPTH
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd  in  2  00 DRAW, 01 RETURN, 10 SWAP, 11 INIT
- cmd_ready  out  1  high when a command can be accepted
- in_value  in  4  card value for RETURN
- in_suit  in  2  card suit for RETURN
- idx_a, idx_b  in  ADDR_W  slot indices for SWAP (0 = bottom of deck)
- out_valid  out  1  one-cycle pulse: card holds a drawn card
- card  out  8  {2'b00, value, suit} of last drawn card
- count  out  ADDR_W  cards currently in deck
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- error  out  1  one-cycle pulse: accepted command rejected

## Operation
- Storage: DEPTH x 6-bit register array; slots are not reset, only count is. Top of deck is slot count-1.
- Accept: a command is accepted on a rising edge with cmd_valid && cmd_ready. Operands are sampled on that edge.
- FSM states: IDLE, SWAP_RD, SWAP_WR, INIT.
  - cmd_ready = 1 only in IDLE and not in reset.
- DRAW (IDLE->IDLE):
  - If count > 0: card <= {2'b00, slot[count-1]}, count decrements, out_valid pulses.
  - Else: error pulses; card and count are unchanged.
- RETURN (IDLE->IDLE):
  - If count < DEPTH and 1 <= in_value <= 13: slot[count] <= {in_value, in_suit}, count increments.
  - Else: error pulses; nothing is written.
- SWAP (IDLE->SWAP_RD->SWAP_WR->IDLE):
  - If idx_a < count and idx_b < count: the indices are latched. SWAP_RD captures both slots into temporaries. SWAP_WR writes them back exchanged.
  - idx_a == idx_b is legal, leaves contents unchanged, and still takes both states.
  - Any index >= count: error pulses and the FSM stays in IDLE.
- INIT (IDLE->INIT->IDLE):
  - Let N = min(DEPTH, 52). count is cleared to 0 on acceptance.
  - Each INIT cycle writes slot k = {value (k mod 13)+1, suit k/13} and increments count.
  - Return to IDLE after slot N-1 is written; final count = N.
  - Never errors; discards the previous deck contents.
- Flags: empty and full are decoded combinationally from count. out_valid and error are never high together.
- Unused widths: card[7:6] is always 0.

## Timing
- Reset (asynchronous assert, any time):
  - state IDLE, count 0, card 0, out_valid 0, error 0.
  - empty 1, full 0, cmd_ready 0 while reset is high.
  - cmd_ready rises in the first cycle after reset falls.
  - Reset during SWAP or INIT aborts the operation; slot contents are undefined afterwards.
- DRAW and RETURN, single cycle:
  - Results (card, count, out_valid/error) are visible in the cycle after the accepting edge.
  - cmd_ready stays high, so back-to-back commands are accepted on consecutive edges.
- SWAP:
  - cmd_ready is low for exactly 2 cycles after acceptance.
  - Swapped contents are visible after the SWAP_WR edge; the next command is accepted 3 edges after the SWAP edge.
- INIT:
  - cmd_ready is low for N cycles.
  - count reads 1..N on successive cycles.
  - A command is accepted no earlier than N+1 edges after the INIT edge.
- Rejected commands (error) cost one cycle; cmd_ready stays high.
- Inputs while cmd_ready = 0 are ignored, and cmd_valid need not be held.
- DRAW followed immediately by RETURN: the returned card lands in the slot just vacated.

## Test plan
- Reset then INIT (DEPTH = 52): ready low for 52 cycles, count = 52, full = 1. Fifty-two DRAWs return suit 3 value 13 first and suit 0 value 1 last, then empty = 1.
- DRAW on empty deck: error pulses one cycle, out_valid stays 0, count stays 0, card stays at its previous value.
- RETURN value 5 suit 2, then DRAW: card = 8'h16, count 1 -> 0. RETURN with value 0 or 14 pulses error and leaves count unchanged.
- After INIT, SWAP idx_a = 0, idx_b = 51, then DRAW: card = {value 1, suit 0}, ready low 2 cycles. SWAP with idx_a = idx_b = 7 leaves contents unchanged; SWAP with idx 52 pulses error.
- DEPTH = 8 instance: INIT gives count = 8 and full = 1. A further RETURN pulses error. DRAW gives value 8 suit 0.
- Assert reset mid-INIT at count = 20: count = 0 and empty = 1 immediately. Ready returns the cycle after deassertion, and a new INIT completes normally.
